// File: rtl/pipe_mem_arbiter_if.sv
// Bus bundle between the CPU pipeline (IF and MEM stages), the unified
// single-port memory and the arbiter that shares that memory.
//   slave  : the arbiter (takes requests and memory read data; drives
//            ready/rdata back to the stages and enable/address/data to memory)
//   master : the stages plus the memory (drive requests and read data)
interface pipe_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Shares one single-port unified memory between instruction fetch (IF) and
// data load/store (MEM). Each granted access occupies the memory for
// WAIT_CYCLES cycles; the grantee then gets a one-cycle ready pulse with its
// read data. stall freezes the pipeline while any request is outstanding.
// Data accesses win over fetches (older instruction) unless fetch has lost
// IF_STARVE_MAX consecutive arbitrations, in which case fetch is forced in.
// Ports:
//   clock : system clock, all state on rising edge
//   reset : asynchronous, active-high
//   bus   : pipe_mem_arbiter_if.slave (IF/MEM request channels, memory side,
//           stall)
module pipe_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES   = 1,
  parameter int unsigned IF_STARVE_MAX = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  pipe_mem_arbiter_if.slave     bus
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned SW = (IF_STARVE_MAX > 0) ? $clog2(IF_STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(WAIT_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(IF_STARVE_MAX);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [SW-1:0] starve_q,    starve_d;
  logic          gnt_if_q,    gnt_if_d;
  logic          mem_en_q,    mem_en_d;
  logic          mem_we_q,    mem_we_d;
  logic [31:0]   mem_addr_q,  mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   if_rdata_q,  if_rdata_d;
  logic [31:0]   dm_rdata_q,  dm_rdata_d;
  logic          if_ready_q,  if_ready_d;
  logic          dm_ready_q,  dm_ready_d;
  logic          if_wins;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    gnt_if_d    = gnt_if_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_wins     = bus.if_req & (~bus.dm_req | (starve_q == STARVE_MAX));

    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          state_d  = ACCESS;
          cnt_d    = CNT_LOAD;
          mem_en_d = 1'b1;
          gnt_if_d = if_wins;
          if (if_wins) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            mem_we_d    = bus.dm_we;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
            // A data grant can only reach this branch at STARVE_MAX when
            // fetch is idle, so the guard doubles as saturation.
            if (bus.if_req && (starve_q != STARVE_MAX))
              starve_d = starve_q + 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (gnt_if_q) begin
            if_rdata_d = bus.mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!mem_we_q)
              dm_rdata_d = bus.mem_rdata;
            dm_ready_d = 1'b1;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      gnt_if_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      gnt_if_q    <= gnt_if_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter. Three instances cover WAIT_CYCLES of
// 1, 2 and 3; each has its own reset and a combinational memory model.
module tb_pipe_mem_arbiter;

  logic clk = 1'b0;
  logic rst1, rst2, rst3;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_mem_arbiter_if b1();
  pipe_mem_arbiter_if b2();
  pipe_mem_arbiter_if b3();

  pipe_mem_arbiter #(.WAIT_CYCLES(1), .IF_STARVE_MAX(4)) u_w1 (
    .clock(clk), .reset(rst1), .bus(b1.slave));
  pipe_mem_arbiter #(.WAIT_CYCLES(2), .IF_STARVE_MAX(4)) u_w2 (
    .clock(clk), .reset(rst2), .bus(b2.slave));
  pipe_mem_arbiter #(.WAIT_CYCLES(3), .IF_STARVE_MAX(4)) u_w3 (
    .clock(clk), .reset(rst3), .bus(b3.slave));

  // Memory contents: two fixed words, everything else reads as ~addr.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h40)      return 32'h8C01_0004;
    else if (a == 32'h10) return 32'h0000_1234;
    else                  return ~a;
  endfunction

  assign b1.mem_rdata = mem_model(b1.mem_addr);
  assign b2.mem_rdata = mem_model(b2.mem_addr);
  assign b3.mem_rdata = mem_model(b3.mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge to the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dm_addr = '0; b1.dm_wdata = '0;
    b2.if_req = 1'b0; b2.if_addr = '0; b2.dm_req = 1'b0; b2.dm_we = 1'b0; b2.dm_addr = '0; b2.dm_wdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.dm_req = 1'b0; b3.dm_we = 1'b0; b3.dm_addr = '0; b3.dm_wdata = '0;

    // Reset values
    tick();
    chk("rst_mem_en",    32'(b1.mem_en),   32'h0);
    chk("rst_mem_we",    32'(b1.mem_we),   32'h0);
    chk("rst_if_ready",  32'(b1.if_ready), 32'h0);
    chk("rst_dm_ready",  32'(b1.dm_ready), 32'h0);
    chk("rst_mem_addr",  b1.mem_addr,      32'h0);
    chk("rst_mem_wdata", b1.mem_wdata,     32'h0);
    chk("rst_if_rdata",  b1.if_rdata,      32'h0);
    chk("rst_dm_rdata",  b1.dm_rdata,      32'h0);
    chk("rst_stall",     32'(b1.stall),    32'h0);
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    tick();

    // Load + fetch together (W=1): data first, fetch two cycles later
    b1.if_req = 1'b1; b1.if_addr = 32'h44;
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h10;
    #1 chk("lf_stall_c0", 32'(b1.stall), 32'h1);
    tick();
    chk("lf_dm_grant_en",   32'(b1.mem_en), 32'h1);
    chk("lf_dm_grant_we",   32'(b1.mem_we), 32'h0);
    chk("lf_dm_grant_addr", b1.mem_addr,    32'h10);
    tick();
    chk("lf_dm_ready",  32'(b1.dm_ready), 32'h1);
    chk("lf_dm_rdata",  b1.dm_rdata,      32'h1234);
    chk("lf_if_not_rdy",32'(b1.if_ready), 32'h0);
    chk("lf_if_stall",  32'(b1.stall),    32'h1);
    b1.dm_req = 1'b0;
    tick();
    chk("lf_if_grant_addr", b1.mem_addr,    32'h44);
    chk("lf_dm_rdy_pulse",  32'(b1.dm_ready), 32'h0);
    tick();
    chk("lf_if_ready",  32'(b1.if_ready), 32'h1);
    chk("lf_if_rdata",  b1.if_rdata,      32'hFFFF_FFBB);
    chk("lf_stall_rdy", 32'(b1.stall),    32'h0);
    b1.if_req = 1'b0;
    tick();
    chk("lf_if_rdy_pulse", 32'(b1.if_ready), 32'h0);
    chk("lf_idle_en",      32'(b1.mem_en),   32'h0);

    // Store (W=1): write qualifiers for one cycle, load data untouched
    b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 32'h20; b1.dm_wdata = 32'hDEAD_BEEF;
    tick();
    chk("st_en",    32'(b1.mem_en), 32'h1);
    chk("st_we",    32'(b1.mem_we), 32'h1);
    chk("st_addr",  b1.mem_addr,    32'h20);
    chk("st_wdata", b1.mem_wdata,   32'hDEAD_BEEF);
    tick();
    chk("st_ready",  32'(b1.dm_ready), 32'h1);
    chk("st_rdata",  b1.dm_rdata,      32'h1234);
    chk("st_we_off", 32'(b1.mem_we),   32'h0);
    b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    tick();

    // Starvation (W=1): both held -> dm x4, if, dm x4, if
    b1.if_req = 1'b1; b1.if_addr = 32'h100;
    b1.dm_req = 1'b1; b1.dm_addr = 32'h200;
    for (int g = 0; g < 10; g++) begin
      automatic bit is_if = (g == 4) || (g == 9);
      tick();
      chk($sformatf("sv_g%0d_en", g),   32'(b1.mem_en), 32'h1);
      chk($sformatf("sv_g%0d_addr", g), b1.mem_addr, is_if ? 32'h100 : 32'h200);
      tick();
      chk($sformatf("sv_g%0d_ifrdy", g), 32'(b1.if_ready), is_if ? 32'h1 : 32'h0);
      chk($sformatf("sv_g%0d_dmrdy", g), 32'(b1.dm_ready), is_if ? 32'h0 : 32'h1);
      if (is_if) chk($sformatf("sv_g%0d_ifdat", g), b1.if_rdata, 32'hFFFF_FEFF);
      else       chk($sformatf("sv_g%0d_dmdat", g), b1.dm_rdata, 32'hFFFF_FDFF);
    end
    b1.if_req = 1'b0; b1.dm_req = 1'b0;
    tick();
    chk("sv_idle_en", 32'(b1.mem_en), 32'h0);

    // Fetch only (W=2): ready in cycle 3, stall in cycles 0..2
    b2.if_req = 1'b1; b2.if_addr = 32'h40;
    #1 chk("f2_stall_c0", 32'(b2.stall), 32'h1);
    tick();
    chk("f2_stall_c1", 32'(b2.stall),    32'h1);
    chk("f2_addr_c1",  b2.mem_addr,      32'h40);
    chk("f2_rdy_c1",   32'(b2.if_ready), 32'h0);
    tick();
    chk("f2_stall_c2", 32'(b2.stall),    32'h1);
    chk("f2_rdy_c2",   32'(b2.if_ready), 32'h0);
    chk("f2_en_c2",    32'(b2.mem_en),   32'h1);
    tick();
    chk("f2_rdy_c3",   32'(b2.if_ready), 32'h1);
    chk("f2_rdata_c3", b2.if_rdata,      32'h8C01_0004);
    chk("f2_stall_c3", 32'(b2.stall),    32'h0);
    b2.if_req = 1'b0;
    tick();
    chk("f2_rdy_c4",   32'(b2.if_ready), 32'h0);

    // Reset mid-access (W=3): abort, no ready, request re-arbitrated
    b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 32'h50;
    tick();
    chk("r3_grant_en", 32'(b3.mem_en), 32'h1);
    tick();
    rst3 = 1'b1;
    #1;
    chk("r3_rst_en",   32'(b3.mem_en),   32'h0);
    chk("r3_rst_addr", b3.mem_addr,      32'h0);
    chk("r3_rst_rdy",  32'(b3.dm_ready), 32'h0);
    tick();
    chk("r3_hold_rdy", 32'(b3.dm_ready), 32'h0);
    rst3 = 1'b0;
    tick();
    chk("r3_regrant_en",   32'(b3.mem_en),   32'h1);
    chk("r3_regrant_addr", b3.mem_addr,      32'h50);
    tick();
    chk("r3_rdy_c2", 32'(b3.dm_ready), 32'h0);
    tick();
    chk("r3_rdy_c3", 32'(b3.dm_ready), 32'h0);
    tick();
    chk("r3_rdy_c4",   32'(b3.dm_ready), 32'h1);
    chk("r3_rdata_c4", b3.dm_rdata,      32'hFFFF_FFAF);
    b3.dm_req = 1'b0;
    tick();

    // Request dropped one cycle after grant (W=3): one ready, no regrant
    b3.dm_req = 1'b1; b3.dm_addr = 32'h60;
    tick();
    chk("dr_grant_addr", b3.mem_addr, 32'h60);
    tick();
    b3.dm_req = 1'b0; b3.dm_addr = 32'h99;
    tick();
    chk("dr_rdy_c3", 32'(b3.dm_ready), 32'h0);
    chk("dr_addr_c3", b3.mem_addr,     32'h60);
    tick();
    chk("dr_rdy_c4",   32'(b3.dm_ready), 32'h1);
    chk("dr_rdata_c4", b3.dm_rdata,      32'hFFFF_FF9F);
    tick();
    chk("dr_rdy_c5", 32'(b3.dm_ready), 32'h0);
    chk("dr_en_c5",  32'(b3.mem_en),   32'h0);
    tick();
    chk("dr_en_c6",  32'(b3.mem_en),   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
